// File: rtl/ec17_pkg.sv
// Shared constants and FSM state type for the F17 modular-inverse datapath.
package ec17_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int MODULUS    = 17;
  localparam int RES_WIDTH  = 5;
  localparam int EXP        = MODULUS - 2;
  localparam int EW         = $clog2(EXP + 1);
  localparam int IDXW       = (EW > 1) ? $clog2(EW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    CHK,
    DONE
  } state_t;

endpackage

// File: rtl/mod17_mulred.sv
// Combinational residue multiply followed by reduction mod MODULUS.
module mod17_mulred
  import ec17_pkg::*;
(
  input  logic [RES_WIDTH-1:0] x,
  input  logic [RES_WIDTH-1:0] y,
  output logic [RES_WIDTH-1:0] p
);

  logic [2*RES_WIDTH-1:0] prod;

  always_comb begin
    prod = {{RES_WIDTH{1'b0}}, x} * {{RES_WIDTH{1'b0}}, y};
    p    = RES_WIDTH'(prod % (2*RES_WIDTH)'(MODULUS));
  end

endmodule

// File: rtl/mod17_inv.sv
// Fermat modular inverse a^(M-2) mod M via square-and-multiply, one op per cycle.
// Build option: MOD17_INV_CHECK_EN adds a CHK state that verifies acc*r == 1.
//
// state | meaning
// IDLE  | waiting for start; operand captured on accept
// LOAD  | reduce operand to canonical residue r, acc = 1
// SQR   | acc = acc^2 mod M
// MUL   | acc = acc*r mod M (exponent bit set)
// CHK   | acc*r == 1 self-check (optional build)
// DONE  | done pulse, result valid
module mod17_inv
  import ec17_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_in,
  output logic                  busy,
  output logic                  done,
  output logic [RES_WIDTH-1:0]  result,
  output logic                  zero_err
);

  localparam logic [EW-1:0] EXP_BITS = EW'(EXP);

  state_t                state;
  logic [DATA_WIDTH-1:0] base;
  logic [RES_WIDTH-1:0]  r;
  logic [RES_WIDTH-1:0]  acc;
  logic [IDXW-1:0]       idx;

  logic                  neg;
  logic [DATA_WIDTH:0]   mag;
  logic [RES_WIDTH-1:0]  rem;
  logic [RES_WIDTH-1:0]  r_load;
  logic [RES_WIDTH-1:0]  mr_y;
  logic [RES_WIDTH-1:0]  mr_p;
  logic                  step_last;

  // Magnitude is one bit wider so negating the most-negative operand cannot overflow.
  always_comb begin
    neg    = base[DATA_WIDTH-1];
    mag    = neg ? (~{1'b1, base}) + (DATA_WIDTH+1)'(1) : {1'b0, base};
    rem    = RES_WIDTH'(mag % (DATA_WIDTH+1)'(MODULUS));
    r_load = (neg && (rem != '0)) ? RES_WIDTH'(MODULUS) - rem : rem;
  end

  always_comb begin
    mr_y      = (state == SQR) ? acc : r;
    step_last = (idx == '0) &&
                (((state == SQR) && !EXP_BITS[idx]) || (state == MUL));
  end

  mod17_mulred u_mulred (
    .x (acc),
    .y (mr_y),
    .p (mr_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero_err <= 1'b0;
      base     <= '0;
      r        <= '0;
      acc      <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base  <= a_in;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          r     <= r_load;
          acc   <= RES_WIDTH'(1);
          idx   <= IDXW'(EW - 1);
          state <= SQR;
        end
        SQR: begin
          acc <= mr_p;
          if (EXP_BITS[idx])    state <= MUL;
          else if (idx != '0)   idx   <= idx - IDXW'(1);
        end
        MUL: begin
          acc   <= mr_p;
          state <= SQR;
          if (idx != '0) idx <= idx - IDXW'(1);
        end
`ifdef MOD17_INV_CHECK_EN
        CHK: begin
          state    <= DONE;
          done     <= 1'b1;
          result   <= (r == '0) ? '0 : acc;
          zero_err <= (r == '0) || (mr_p != RES_WIDTH'(1));
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Leaving the exponent loop overrides the loop's own next-state choice.
      if (step_last) begin
`ifdef MOD17_INV_CHECK_EN
        state    <= CHK;
`else
        state    <= DONE;
        done     <= 1'b1;
        result   <= (r == '0) ? '0 : mr_p;
        zero_err <= (r == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mod17_inv.sv
// Self-checking bench for mod17_inv: cycle-level reference model plus directed literal vectors.
module tb_mod17_inv;
  import ec17_pkg::*;

`ifdef MOD17_INV_CHECK_EN
  localparam int N = 2 + EW + $countones(EXP) + 1;
`else
  localparam int N = 2 + EW + $countones(EXP);
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [DATA_WIDTH-1:0] a_in = '0;
  logic                  busy, done, zero_err;
  logic [RES_WIDTH-1:0]  result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mod17_inv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero_err (zero_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: canonical residue by signed remainder, inverse by exhaustive search.
  function automatic logic [RES_WIDTH:0] model(input logic [DATA_WIDTH-1:0] a);
    longint sa;
    int     rr;
    sa = longint'(a);
    rr = int'(sa % longint'(MODULUS));
    if (rr < 0) rr += MODULUS;
    if (rr == 0) return {1'b1, {RES_WIDTH{1'b0}}};
    for (int x = 1; x < MODULUS; x++)
      if (((rr * x) % MODULUS) == 1) return {1'b0, RES_WIDTH'(x)};
    return '1;
  endfunction

  // Cycle model: m_cyc is the number of cycles since the accepting edge (0 = idle).
  int                    m_cyc = 0;
  logic                  m_busy = 1'b0, m_done = 1'b0, m_zerr = 1'b0;
  logic [RES_WIDTH-1:0]  m_res = '0;
  logic [DATA_WIDTH-1:0] m_a = '0;

  always @(posedge clk) begin
    logic [RES_WIDTH:0] mv;
    if (!rst_n) begin
      m_cyc = 0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_zerr = 1'b0;
    end else if (m_cyc == 0) begin
      if (start) begin
        m_a = a_in; m_cyc = 1; m_busy = 1'b1;
      end
    end else begin
      m_cyc++;
      if (m_cyc > N) begin
        m_cyc = 0; m_busy = 1'b0; m_done = 1'b0;
      end else if (m_cyc == N) begin
        mv = model(m_a);
        m_done = 1'b1;
        m_res  = mv[RES_WIDTH-1:0];
        m_zerr = mv[RES_WIDTH];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (m_done) begin
        chk("result", result, m_res);
        chk("zero_err", zero_err, m_zerr);
      end else if (m_cyc == 0) begin
        chk("result_hold", result, m_res);
      end
    end
  end

  task automatic run_op(input string name, input logic [DATA_WIDTH-1:0] a,
                        input bit lit, input logic [RES_WIDTH-1:0] er, input bit ez);
    int lat;
    @(negedge clk);
    start = 1'b1; a_in = a;
    @(negedge clk);
    start = 1'b0; a_in = ~a;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 4) begin start = 1'b1; a_in = 64'd7; end
      else start = 1'b0;
    end
    chk({name, "_latency"}, lat, N);
    if (lit) begin
      chk({name, "_result"}, result, er);
      chk({name, "_zero_err"}, zero_err, ez);
      chk({name, "_no17"}, (result == RES_WIDTH'(MODULUS)), 0);
    end
    start = 1'b0;
  endtask

  initial begin
    int first, second, dcnt;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_zero_err", zero_err, 0);
    rst_n = 1'b1;

    run_op("a3",     64'd3,                  1, 5'd6,  0);
    run_op("a2",     64'd2,                  1, 5'd9,  0);
    run_op("a35",    64'd35,                 1, 5'd1,  0);
    run_op("a16",    64'd16,                 1, 5'd16, 0);
    run_op("am1",    '1,                     1, 5'd16, 0);
    run_op("am17",   -64'sd17,               1, 5'd0,  1);
    run_op("amin",   64'h8000_0000_0000_0000, 1, 5'd15, 0);
    run_op("amax",   64'h7FFF_FFFF_FFFF_FFFF, 0, 5'd0,  0);
    for (int v = -40; v <= 40; v++)
      run_op("sweep", DATA_WIDTH'(v), 0, 5'd0, 0);

    // start held with a changing operand: only the first value runs, then a re-accept.
    first = -1; second = -1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) begin
          first = c;
          chk("held_start_result", result, 5'd7);
        end else if (second < 0) second = c;
      end
      if (c < 15) begin start = 1'b1; a_in = DATA_WIDTH'(5 + c); end
      else start = 1'b0;
    end
    chk("held_first_done_cycle", first, N);
    chk("held_done_gap", (second >= 0) && ((second - first) >= 11), 1);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; a_in = 64'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_result", result, 0);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("aborted_done_count", dcnt, 0);
    run_op("post_reset", 64'd3, 1, 5'd6, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
